// File: rtl/mips_div_pkg.sv
// Shared types and constants for the iterative HI/LO divider.
package mips_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_STEPS   = 32;
    localparam int DIV_LATENCY = 34;

endpackage

// File: rtl/mips_div_if.sv
// Execute-stage to divider bundle: request operands in, HI/LO result out.
interface mips_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_div_step.sv
// One combinational restoring-division iteration on {rem, quo}.
module mips_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dmag,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0]   w_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_ok;

    // rem < dmag holds on entry, so a successful trial always fits in WIDTH bits
    assign w_sh   = {i_rem, i_quo[WIDTH-1]};
    assign w_ok   = (w_sh >= {1'b0, i_dmag});
    assign w_diff = w_sh[WIDTH-1:0] - i_dmag;
    assign o_rem  = w_ok ? w_diff : w_sh[WIDTH-1:0];
    assign o_quo  = {i_quo[WIDTH-2:0], w_ok};
endmodule

// File: rtl/mips_div_unit.sv
// Fixed-latency iterative DIV/DIVU unit producing LO (quotient) and HI (remainder).
module mips_div_unit
    import mips_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      clk_enable,
    mips_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    div_state_t       r_state;
    div_state_t       w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_signed;
    logic             r_neg_dvd;
    logic             r_neg_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dmag;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_quo;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic             w_last;

    assign w_dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign w_dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -bus.dividend : bus.dividend;
    assign w_dvs_mag = w_dvs_neg ? -bus.divisor : bus.divisor;
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    mips_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_quo  (r_quo),
        .i_dmag (r_dmag),
        .o_rem  (w_step_rem),
        .o_quo  (w_step_quo)
    );

    // Zero divisor leaves the dividend magnitude in rem, so the sign fix restores it
    assign w_quo_fix = (r_dmag == '0) ? '1 :
                       (r_signed && (r_neg_dvd ^ r_neg_dvs)) ? -r_quo : r_quo;
    assign w_rem_fix = (r_signed && r_neg_dvd) ? -r_rem : r_rem;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (bus.start) w_next = RUN;
            RUN:  if (w_last) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else if (clk_enable) begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_signed  <= 1'b0;
            r_neg_dvd <= 1'b0;
            r_neg_dvs <= 1'b0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dmag    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (clk_enable) begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_cnt     <= '0;
                        r_signed  <= bus.is_signed;
                        r_neg_dvd <= w_dvd_neg;
                        r_neg_dvs <= w_dvs_neg;
                        r_rem     <= '0;
                        r_quo     <= w_dvd_mag;
                        r_dmag    <= w_dvs_mag;
                    end
                end
                RUN: begin
                    r_rem <= w_step_rem;
                    r_quo <= w_step_quo;
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = (r_state == DONE);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mips_div_unit.sv
// Directed checks of the divider: results, latency, stalls, aborts, ignored starts.
module tb_mips_div_unit;
    import mips_div_pkg::*;

    logic clk;
    logic reset;
    logic clk_enable;
    int   tests;
    int   fails;

    mips_div_if #(.WIDTH(32)) bus ();

    mips_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one op; edge counter n is 1 on the start-accepting edge
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi,
                          input int stall_at, input int inject_at, input string tag);
        int n;
        bit busy_ok;
        int exp_lat;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        n = 1;
        busy_ok = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && n < 200) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (n == stall_at) clk_enable = 1'b0;
            if (n == stall_at + 5) clk_enable = 1'b1;
            if (n == inject_at) begin
                bus.start     = 1'b1;
                bus.is_signed = ~s;
                bus.dividend  = 32'h0000DEAD;
                bus.divisor   = 32'd3;
            end
            if (n == inject_at + 1) bus.start = 1'b0;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        exp_lat = DIV_LATENCY + ((stall_at < 1000) ? 5 : 0);
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " lo"}, bus.lo, elo);
        chk({tag, " hi"}, bus.hi, ehi);
        chk({tag, " busy_run"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, " busy_done"}, {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, " done_pulse"}, {31'd0, bus.done}, 32'd0);
        chk({tag, " idle"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, " lo_held"}, bus.lo, elo);
        chk({tag, " hi_held"}, bus.hi, ehi);
    endtask

    initial begin
        int  n;
        bit  saw_done;
        tests         = 0;
        fails         = 0;
        reset         = 1'b1;
        clk_enable    = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst done", {31'd0, bus.done}, 32'd0);
        chk("rst hi", bus.hi, 32'd0);
        chk("rst lo", bus.lo, 32'd0);
        reset = 1'b0;

        do_div(1'b0, 32'd77, 32'd11, 32'd7, 32'd0, 1000, 1000, "divu77_11");
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1000, 1000, "div_m7_2");
        do_div(1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1000, 1000, "divu_m7_2");
        do_div(1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1000, 1000, "divu_by0");
        do_div(1'b1, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF0, 1000, 1000, "div_by0");
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1000, 1000, "div_ovf");
        do_div(1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1000, 20, "ign_start");
        do_div(1'b0, 32'd1000, 32'd7, 32'd142, 32'd6, 10, 1000, "stall5");

        // Reset abort in the middle of RUN
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd500;
        bus.divisor   = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort done", {31'd0, bus.done}, 32'd0);
        chk("abort hi", bus.hi, 32'd0);
        chk("abort lo", bus.lo, 32'd0);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        chk("abort quiet", {31'd0, saw_done}, 32'd0);

        // Back-to-back with start held high throughout
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd100;
        bus.divisor   = 32'd7;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        while (!bus.done && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("b2b_a latency", 32'(n), 32'(DIV_LATENCY));
        chk("b2b_a lo", bus.lo, 32'd14);
        chk("b2b_a hi", bus.hi, 32'd2);
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd10;
        @(posedge clk);
        n++;
        @(negedge clk);
        chk("b2b_a pulse", {31'd0, bus.done}, 32'd0);
        chk("b2b_a idle", {31'd0, bus.busy}, 32'd0);
        while (!bus.done && n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("b2b_b latency", 32'(n), 32'(2 * DIV_LATENCY + 1));
        chk("b2b_b lo", bus.lo, 32'd100);
        chk("b2b_b hi", bus.hi, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_b pulse", {31'd0, bus.done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mips_div_unit.md
Name: mips_div_unit

Overview:
- Iterative multi-cycle divider consumed by the execute stage of mips_cpu_harvard for DIV and DIVU.
- Takes operands from the register-read stage.
- Produces quotient (LO) and remainder (HI) for the HI/LO register write-back.
- The CPU stalls on busy and writes HI/LO on done.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on a rising edge where high
- clk_enable  input  1  global CPU clock enable; when low, all state (including counter) holds
- start  input  1  request a division; sampled only in IDLE with clk_enable high
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; captured with start
- dividend  input  WIDTH  rs operand; captured with start
- divisor  input  WIDTH  rt operand; captured with start
- busy  output  1  high from the cycle after start is accepted until done deasserts
- done  output  1  one-cycle pulse; hi/lo valid in this cycle
- hi  output  WIDTH  remainder; held until the next accepted start
- lo  output  WIDTH  quotient; held until the next accepted start

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal registers=0.
- Reset mid-operation: aborts immediately to IDLE with reset values. No done pulse.
- States: IDLE, RUN, FIX, DONE.
- IDLE, start=1 (clk_enable=1):
  - latch is_signed and sign of each operand
  - load magnitudes: abs() if is_signed, else raw
  - clear partial remainder, counter=0
  - go to RUN
- RUN: one restoring step per enabled edge:
  - shift {rem, quo} left 1; trial = rem - divisor_mag (WIDTH+1 bits)
  - if no borrow, rem = trial and quo LSB = 1
  - after counter reaches WIDTH-1 (32 steps), go to FIX
- FIX (1 edge):
  - signed: negate quotient if operand signs differ; remainder takes dividend's sign
  - write hi/lo
  - go to DONE
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: done is high in the cycle after the 34th enabled rising edge counting the start-accepting edge as edge 1 (1 load + 32 steps + 1 fix). The fixed latency does not depend on the data.
- busy = (state != IDLE). It is high during DONE and low in IDLE.
- start while not IDLE is ignored. Operands are not re-sampled.
- start in the same cycle that done is high is ignored. The CPU must reassert it in IDLE.
- clk_enable=0: no transition, no counter advance, outputs held. Latency stretches by the number of disabled cycles.
- Divide by zero (same latency, no trap):
  - lo = all ones for DIVU and DIV, forced in FIX regardless of signs
  - hi = original dividend
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0. This is the natural two's-complement wrap.
- Magnitude arithmetic uses WIDTH bits unsigned. abs(0x80000000) = 0x80000000 is valid as unsigned.

Decomposition:
- Package mips_div_pkg holds:
  - div_state_t enum {IDLE, RUN, FIX, DONE}
  - localparam DIV_STEPS = 32
  - localparam DIV_LATENCY = 34
- One sub-module is natural: mips_div_step. It is purely combinational: one restoring iteration, taking rem, quo, and divisor_mag and returning the next rem and quo.
- The FSM, counter and sign fixup stay in mips_div_unit.

Test Plan:
- DIVU 77 / 11, start for 1 cycle with clk_enable=1 -> done exactly 34 edges later; lo=7, hi=0; busy high throughout; hi/lo stable after done.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU of the same operands -> lo=0x7FFFFFFC, hi=1.
- Divisor 0: DIVU 0x12345678/0 and DIV 0xFFFFFFF0/0 -> lo=0xFFFFFFFF, hi equals the dividend; latency still 34.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, no hang.
- Interruptions and stalls:
  - assert reset at RUN step 10 -> next cycle busy=0, hi=lo=0, no done
  - new start at step 20 -> ignored, first result unaffected
  - clk_enable=0 for 5 cycles mid-RUN -> done arrives 5 cycles later with correct result
- Back-to-back: start held high continuously across two operations -> second operation begins only from IDLE after done. Each done is a single-cycle pulse with correct per-operation results.
